lcd_cls_command_responder: RTL and testbench



---
 rtl/lcd_cls_pkg.sv | 54 +++++
 rtl/lcd_cls_command_responder_esc_rom.sv | 29 ++
 rtl/lcd_cls_command_responder.sv | 191 +++++++++++++++++++
 tb/tb_lcd_cls_command_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cls_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cls_pkg
// Description : Shared types and constants for the Pmod CLS command responder.
//               State and command enums, the ASCII escape sequences that
//               precede each command, and a helper that picks one character
//               out of a 16-character text line.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_cls_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ESC   = 3'd1,
    ST_TEXT  = 3'd2,
    ST_GUARD = 3'd3,
    ST_DONE  = 3'd4
  } t_cls_resp_state;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_LINE1 = 2'd1,
    CMD_LINE2 = 2'd2
  } t_cls_cmd;

  // Number of text characters written after a cursor-position sequence.
  localparam int c_text_len = 16;

  // Escape sequences, padded to 8 entries so a 3-bit index never leaves
  // the array.
  // clear display : ESC [ j
  localparam logic [7:0] c_esc_clear [0:7] = '{
    8'h1B, 8'h5B, 8'h6A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  // cursor to row 0, column 0 : ESC [ 0 ; 0 H
  localparam logic [7:0] c_esc_line1 [0:7] = '{
    8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h48, 8'h00, 8'h00
  };
  // cursor to row 1, column 0 : ESC [ 1 ; 0 H
  localparam logic [7:0] c_esc_line2 [0:7] = '{
    8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h48, 8'h00, 8'h00
  };

  // Escape length per command, indexed by t_cls_cmd (entry 3 is unused).
  localparam logic [2:0] c_esc_len [0:3] = '{3'd3, 3'd6, 3'd6, 3'd3};

  // Character idx of a line; character 0 occupies bits [127:120].
  function automatic logic [7:0] get_text_char(input logic [127:0] line,
                                               input logic [3:0]   idx);
    return line[8*(15 - int'(idx)) +: 8];
  endfunction

endpackage : lcd_cls_pkg
`default_nettype wire

// File: rtl/lcd_cls_command_responder_esc_rom.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cls_command_responder_esc_rom
// Description : Combinational escape-sequence ROM, command + index -> byte.
// Ports       : i_cmd  - command whose sequence is being read
//               i_idx  - byte position within the sequence (0..7)
//               o_byte - escape byte at that position
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cls_command_responder_esc_rom
  import lcd_cls_pkg::*;
(
  input  t_cls_cmd   i_cmd,
  input  logic [2:0] i_idx,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_cmd)
      CMD_CLEAR: o_byte = c_esc_clear[i_idx];
      CMD_LINE1: o_byte = c_esc_line1[i_idx];
      CMD_LINE2: o_byte = c_esc_line2[i_idx];
      default:   o_byte = 8'h00;
    endcase
  end

endmodule : lcd_cls_command_responder_esc_rom
`default_nettype wire

// File: rtl/lcd_cls_command_responder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cls_command_responder
// Description : Responder end of the LCD command strobe interface. Accepts
//               clear / write-line-1 / write-line-2 level requests, serialises
//               each into Pmod CLS escape + text bytes on a valid/ready byte
//               stream, then holds busy for a guard interval before
//               re-asserting command-ready.
// Ports       : i_clk_20mhz        - system clock
//               i_rst_20mhz        - asynchronous active-high reset
//               i_wr_clear_display - request: clear display (highest prio)
//               i_wr_text_line1    - request: write line 1
//               i_wr_text_line2    - request: write line 2 (lowest prio)
//               i_dat_ascii_line1  - 16 chars, char 0 in [127:120]
//               i_dat_ascii_line2  - 16 chars, char 0 in [127:120]
//               o_command_ready    - high only while idle
//               o_tx_data          - byte to SPI transmitter
//               o_tx_valid         - byte valid
//               i_tx_ready         - transmitter accepts when valid && ready
//               o_cmd_done         - one-cycle pulse at end of guard interval
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cls_command_responder
  import lcd_cls_pkg::*;
#(
  parameter int PARM_GUARD_CYCLES    = 20000,
  parameter bit PARM_FAST_SIMULATION = 1'b0
)
(
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_wr_clear_display,
  input  logic         i_wr_text_line1,
  input  logic         i_wr_text_line2,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  output logic         o_command_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_cmd_done
);

  localparam int          c_guard      = PARM_FAST_SIMULATION ? 200 : PARM_GUARD_CYCLES;
  localparam logic [15:0] c_guard_last = 16'(c_guard - 1);
  localparam logic [3:0]  c_text_last  = 4'(c_text_len - 1);

  t_cls_resp_state r_state;
  t_cls_cmd        r_cmd;
  logic [127:0]    r_line;
  logic [2:0]      r_esc_idx;
  logic [3:0]      r_txt_idx;
  logic [15:0]     r_guard_cnt;

  t_cls_cmd        w_req_cmd;
  logic            w_any_req;
  logic [127:0]    w_req_line;
  t_cls_cmd        w_rom_cmd;
  logic [2:0]      w_rom_idx;
  logic [7:0]      w_rom_byte;
  logic [3:0]      w_char_idx;
  logic [7:0]      w_char;
  logic            w_handshake;
  logic            w_esc_last;
  logic            w_text_last;

  // Request priority: clear > line1 > line2.
  always_comb begin
    w_any_req  = i_wr_clear_display | i_wr_text_line1 | i_wr_text_line2;
    w_req_cmd  = CMD_LINE2;
    w_req_line = i_dat_ascii_line2;
    if (i_wr_clear_display) begin
      w_req_cmd  = CMD_CLEAR;
      w_req_line = i_dat_ascii_line1;
    end else if (i_wr_text_line1) begin
      w_req_cmd  = CMD_LINE1;
      w_req_line = i_dat_ascii_line1;
    end
  end

  // The ROM always looks one byte ahead: while idle it presents byte 0 of the
  // command about to be accepted, otherwise the byte after the current one.
  always_comb begin
    w_rom_cmd = r_cmd;
    w_rom_idx = r_esc_idx + 3'd1;
    if (r_state == ST_IDLE) begin
      w_rom_cmd = w_req_cmd;
      w_rom_idx = 3'd0;
    end
  end

  lcd_cls_command_responder_esc_rom u_esc_rom (
    .i_cmd  (w_rom_cmd),
    .i_idx  (w_rom_idx),
    .o_byte (w_rom_byte)
  );

  // Next text character: char 0 when leaving the escape phase, else idx+1.
  always_comb begin
    w_char_idx = (r_state == ST_TEXT) ? (r_txt_idx + 4'd1) : 4'd0;
    w_char     = get_text_char(r_line, w_char_idx);
  end

  assign w_handshake = o_tx_valid & i_tx_ready;
  assign w_esc_last  = (r_esc_idx == (c_esc_len[r_cmd] - 3'd1));
  assign w_text_last = (r_txt_idx == c_text_last);

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_state         <= ST_IDLE;
      r_cmd           <= CMD_CLEAR;
      r_line          <= '0;
      r_esc_idx       <= 3'd0;
      r_txt_idx       <= 4'd0;
      r_guard_cnt     <= 16'd0;
      o_command_ready <= 1'b1;
      o_tx_data       <= 8'h00;
      o_tx_valid      <= 1'b0;
      o_cmd_done      <= 1'b0;
    end else begin
      o_cmd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_cmd           <= w_req_cmd;
            r_line          <= w_req_line;
            r_esc_idx       <= 3'd0;
            o_tx_data       <= w_rom_byte;
            o_tx_valid      <= 1'b1;
            o_command_ready <= 1'b0;
            r_state         <= ST_ESC;
          end
        end

        ST_ESC: begin
          if (w_handshake) begin
            if (w_esc_last) begin
              if (r_cmd == CMD_CLEAR) begin
                o_tx_valid  <= 1'b0;
                r_guard_cnt <= 16'd0;
                r_state     <= ST_GUARD;
              end else begin
                r_txt_idx <= 4'd0;
                o_tx_data <= w_char;
                r_state   <= ST_TEXT;
              end
            end else begin
              r_esc_idx <= r_esc_idx + 3'd1;
              o_tx_data <= w_rom_byte;
            end
          end
        end

        ST_TEXT: begin
          if (w_handshake) begin
            if (w_text_last) begin
              o_tx_valid  <= 1'b0;
              r_guard_cnt <= 16'd0;
              r_state     <= ST_GUARD;
            end else begin
              r_txt_idx <= r_txt_idx + 4'd1;
              o_tx_data <= w_char;
            end
          end
        end

        ST_GUARD: begin
          if (r_guard_cnt == c_guard_last) begin
            o_cmd_done <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 16'd1;
          end
        end

        ST_DONE: begin
          o_command_ready <= 1'b1;
          r_state         <= ST_IDLE;
        end

        default: begin
          o_tx_valid      <= 1'b0;
          o_command_ready <= 1'b1;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : lcd_cls_command_responder
`default_nettype wire

// File: tb/tb_lcd_cls_command_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cls_command_responder
// Description : Self-checking bench for lcd_cls_command_responder. One
//               instance uses the full 20000-cycle guard, one uses fast
//               simulation (200 cycles). Expected byte streams come from a
//               queue-based model built from the command definitions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cls_command_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_clear = 1'b0, wr_l1 = 1'b0, wr_l2 = 1'b0;
  logic [127:0] line1 = '0, line2 = '0;
  logic         tx_ready = 1'b0;

  logic         f_ready, f_valid, f_done;
  logic [7:0]   f_data;
  logic         s_ready, s_valid, s_done;
  logic [7:0]   s_data;

  always #25 clk = ~clk;

  lcd_cls_command_responder #(.PARM_GUARD_CYCLES(20000), .PARM_FAST_SIMULATION(1'b1)) dut_fast (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst),
    .i_wr_clear_display(wr_clear), .i_wr_text_line1(wr_l1), .i_wr_text_line2(wr_l2),
    .i_dat_ascii_line1(line1), .i_dat_ascii_line2(line2),
    .o_command_ready(f_ready), .o_tx_data(f_data), .o_tx_valid(f_valid),
    .i_tx_ready(tx_ready), .o_cmd_done(f_done)
  );

  lcd_cls_command_responder #(.PARM_GUARD_CYCLES(20000), .PARM_FAST_SIMULATION(1'b0)) dut_slow (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst),
    .i_wr_clear_display(wr_clear), .i_wr_text_line1(wr_l1), .i_wr_text_line2(wr_l2),
    .i_dat_ascii_line1(line1), .i_dat_ascii_line2(line2),
    .o_command_ready(s_ready), .o_tx_data(s_data), .o_tx_valid(s_valid),
    .i_tx_ready(tx_ready), .o_cmd_done(s_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // 0: tx_ready held, 1: toggles each cycle, 2: random
  int ready_mode = 0;

  logic [7:0] q_f[$];
  logic [7:0] q_s[$];
  logic [7:0] exp_q[$];
  int         f_quiet, s_quiet, f_done_cnt, s_done_cnt, s_vcnt, stall_viol;
  bit         stall_pend;
  logic [7:0] stall_data;

  // Reference model: byte stream for one command.
  function automatic void add_expected(input int kind, input logic [127:0] line);
    logic [127:0] tmp;
    tmp = line;
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    if (kind == 0) begin
      exp_q.push_back(8'h6A);
    end else begin
      exp_q.push_back(kind == 1 ? 8'h30 : 8'h31);
      exp_q.push_back(8'h3B);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h48);
      for (int i = 0; i < 16; i++) exp_q.push_back(tmp[127-8*i -: 8]);
    end
  endfunction

  function automatic logic [127:0] rand_line();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic int first_diff();
    if (q_f.size() != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++) if (q_f[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic clear_obs();
    q_f.delete(); q_s.delete(); exp_q.delete();
    f_quiet = 0; s_quiet = 0; f_done_cnt = 0; s_done_cnt = 0;
    s_vcnt = 0; stall_viol = 0; stall_pend = 0;
  endtask

  // One clock: observe at the falling edge, advance, then update tx_ready.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (f_valid && tx_ready) q_f.push_back(f_data);
      if (s_valid && tx_ready) q_s.push_back(s_data);
      if (stall_pend && (!f_valid || f_data !== stall_data)) stall_viol++;
      stall_pend = f_valid && !tx_ready;
      stall_data = f_data;
      if (!f_valid && !f_ready && !f_done) f_quiet++;
      if (!s_valid && !s_ready && !s_done) s_quiet++;
      if (f_done) f_done_cnt++;
      if (s_done) s_done_cnt++;
      if (s_valid) s_vcnt++;
    end else begin
      stall_pend = 0;
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_clear = 0; wr_l1 = 0; wr_l2 = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    clear_obs();
  endtask

  // Drive one command on the fast instance and wait for its done pulse.
  task automatic issue(input int kind, output bit tmo);
    int n;
    int start;
    start = f_done_cnt;
    tmo = 0;
    wr_clear = (kind == 0); wr_l1 = (kind == 1); wr_l2 = (kind == 2);
    n = 0;
    while (f_ready && n < 10) begin step(); n++; end
    if (f_ready) tmo = 1;
    wr_clear = 0; wr_l1 = 0; wr_l2 = 0;
    n = 0;
    while (f_done_cnt == start && n < 2000) begin step(); n++; end
    if (f_done_cnt == start) tmo = 1;
  endtask

  task automatic test_reset();
    n_checks++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", f_ready); end
    n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", f_valid); end
    n_checks++; if (f_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", f_data); end
    n_checks++; if (f_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", f_done); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_slow: got %b expected 1", s_ready); end
  endtask

  task automatic test_clear_full_guard();
    int n;
    ready_mode = 0; tx_ready = 1'b1;
    wr_clear = 1'b1;
    step();
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_fall: got %b expected 0", s_ready); end
    wr_clear = 1'b0;
    n = 0;
    while (s_done_cnt == 0 && n < 25000) begin step(); n++; end
    n_checks++; if (s_done_cnt == 0) begin n_fail++; $display("FAIL clr_done_timeout: got %0d pulses expected 1", s_done_cnt); end
    n_checks++;
    if (q_s.size() != 3 || q_s[0] !== 8'h1B || q_s[1] !== 8'h5B || q_s[2] !== 8'h6A) begin
      n_fail++; $display("FAIL clr_bytes: got %0d bytes first %h expected 1B 5B 6A", q_s.size(), (q_s.size() > 0) ? q_s[0] : 8'hxx);
    end
    n_checks++; if (s_vcnt != 3) begin n_fail++; $display("FAIL clr_valid_cycles: got %0d expected 3", s_vcnt); end
    n_checks++; if (s_quiet != 20000) begin n_fail++; $display("FAIL clr_guard_len: got %0d expected 20000", s_quiet); end
    n_checks++; if (s_ready !== 1'b1 || s_done !== 1'b0) begin n_fail++; $display("FAIL clr_after_done: got ready=%b done=%b expected ready=1 done=0", s_ready, s_done); end
  endtask

  task automatic test_line1_toggle();
    bit tmo;
    int d;
    line1 = "ACCEL X:+0.012 g";
    add_expected(1, line1);
    ready_mode = 1; tx_ready = 1'b1;
    issue(1, tmo);
    ready_mode = 0;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL l1_timeout: got timeout expected done"); end
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL l1_bytes: got %0d bytes (diff at %0d) expected 22", q_f.size(), d); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL l1_stall_stable: got %0d violations expected 0", stall_viol); end
    n_checks++; if (f_quiet != 200) begin n_fail++; $display("FAIL l1_guard_len: got %0d expected 200", f_quiet); end
  endtask

  task automatic test_priority();
    int n;
    int d;
    line1 = rand_line(); line2 = rand_line();
    add_expected(0, line1);
    add_expected(1, line1);
    ready_mode = 0; tx_ready = 1'b1;
    wr_clear = 1; wr_l1 = 1; wr_l2 = 1;
    step();
    wr_clear = 0;
    n = 0;
    while (f_done_cnt == 0 && n < 1000) begin step(); n++; end
    n_checks++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_back: got %b expected 1", f_ready); end
    step();
    n_checks++; if (f_ready !== 1'b0) begin n_fail++; $display("FAIL prio_reaccept: got ready=%b expected 0", f_ready); end
    wr_l1 = 0; wr_l2 = 0;
    n = 0;
    while (f_done_cnt < 2 && n < 1000) begin step(); n++; end
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL prio_bytes: got %0d bytes (diff at %0d) expected %0d", q_f.size(), d, exp_q.size()); end
    n_checks++; if (f_quiet != 400) begin n_fail++; $display("FAIL prio_guard_total: got %0d expected 400", f_quiet); end
  endtask

  task automatic test_line2_change();
    int n;
    int d;
    line2 = rand_line();
    add_expected(2, line2);
    ready_mode = 2;
    wr_l2 = 1;
    step();
    wr_l2 = 0;
    for (int k = 0; k < 20; k++) begin
      line1 = rand_line(); line2 = rand_line();
      step();
    end
    n = 0;
    while (f_done_cnt == 0 && n < 1000) begin step(); n++; end
    ready_mode = 0;
    d = first_diff();
    n_checks++; if (d != -1) begin n_fail++; $display("FAIL l2_latched: got %0d bytes (diff at %0d) expected 22", q_f.size(), d); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL l2_stall_stable: got %0d violations expected 0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    int n;
    line2 = rand_line();
    add_expected(2, line2);
    ready_mode = 0; tx_ready = 1'b1;
    wr_l2 = 1;
    step();
    wr_l2 = 0;
    n = 0;
    while (q_f.size() < 9 && n < 100) begin step(); n++; end
    tx_ready = 1'b0;
    step(); step();
    n_checks++; if (f_valid !== 1'b1 || f_data !== exp_q[9]) begin n_fail++; $display("FAIL rm_tenth_byte: got valid=%b data=%h expected 1 %h", f_valid, f_data, exp_q[9]); end
    rst = 1'b1;
    #1;
    n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid: got %b expected 0", f_valid); end
    step(); step();
    rst = 1'b0;
    step();
    n_checks++; if (f_ready !== 1'b1 || f_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after_release: got ready=%b valid=%b expected 1 0", f_ready, f_valid); end
    tx_ready = 1'b1;
    repeat (50) step();
    n_checks++; if (q_f.size() != 9) begin n_fail++; $display("FAIL rm_no_trailing: got %0d bytes expected 9", q_f.size()); end
  endtask

  task automatic test_feed_loop();
    bit tmo;
    int d;
    ready_mode = 2;
    for (int loop = 0; loop < 3; loop++) begin
      q_f.delete(); exp_q.delete();
      for (int kind = 0; kind < 3; kind++) begin
        line1 = rand_line(); line2 = rand_line();
        add_expected(kind, (kind == 2) ? line2 : line1);
        f_quiet = 0;
        issue(kind, tmo);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL feed_timeout: got timeout on kind %0d expected done", kind); end
        n_checks++; if (f_quiet != 200) begin n_fail++; $display("FAIL feed_guard: got %0d expected 200 (kind %0d)", f_quiet, kind); end
        step();
      end
      n_checks++; if (q_f.size() != 47) begin n_fail++; $display("FAIL feed_loop_count: got %0d expected 47", q_f.size()); end
      d = first_diff();
      n_checks++; if (d != -1) begin n_fail++; $display("FAIL feed_loop_bytes: got diff at %0d expected none", d); end
    end
    ready_mode = 0;
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL feed_stall_stable: got %0d violations expected 0", stall_viol); end
  endtask

  initial begin
    clear_obs();
    do_reset();
    test_reset();
    test_clear_full_guard();
    do_reset();
    test_line1_toggle();
    do_reset();
    test_priority();
    do_reset();
    test_line2_change();
    do_reset();
    test_reset_mid();
    do_reset();
    test_feed_loop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lcd_cls_command_responder
`default_nettype wire
